// File: rtl/rx_fifo_pkg.sv
// Shared defaults and helpers for the UART receive buffer.
// Imported by the FIFO core and its edge detector.
package rx_fifo_pkg;

  localparam int INPUT_DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF            = 16;

  // Wrap-bit pointer compare: same slot, opposite lap.
  function automatic logic ptr_full(
    input logic [31:0] wr,
    input logic [31:0] rd,
    input int          aw
  );
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return ((wr & mask) == (rd & mask)) &&
           (wr[aw] != rd[aw]);
  endfunction

endpackage

// File: rtl/rx_fifo_rise_detect.sv
// Converts the receiver's level word-valid into a one-cycle capture pulse.
// dv_q is cleared by reset so a level held through reset captures once.
module rx_fifo_rise_detect
  import rx_fifo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic dv_q;

  always_ff @(posedge clk) begin
    if (reset) dv_q <= 1'b0;
    else       dv_q <= level;
  end

  assign pulse = level & ~dv_q;

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-captured writes,
// show-ahead valid/ready read side, count and sticky overflow status.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = INPUT_DATA_WIDTH_DEF,
  parameter int DEPTH            = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0] received_data,
  input  logic                        data_is_valid,
  input  logic                        rx_error,
  output logic [INPUT_DATA_WIDTH-1:0] out_data,
  output logic                        out_error,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
  input  logic                        overflow_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = INPUT_DATA_WIDTH + 1;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [31:0]   wr_ext;
  logic [31:0]   rd_ext;
  logic          cap;
  logic          push;
  logic          pop;
  logic          drop;

  rx_fifo_rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .level (data_is_valid),
    .pulse (cap)
  );

  assign wr_ext = 32'(wr_ptr);
  assign rd_ext = 32'(rd_ptr);

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ptr_full(wr_ext, rd_ext, AW);
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = ~empty;

  assign pop  = out_valid & out_ready;
  // A pop frees the slot a full-FIFO capture lands in.
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_data  = head[INPUT_DATA_WIDTH-1:0];
  assign out_error = head[EW-1];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {rx_error, received_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Set beats clear when both land together.
  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (overflow_clear) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo with a queue model and per-cycle compare.
// Literal checks pin the model at key points of each scenario.
module tb_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = '0;
  logic       data_is_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] out_data;
  logic       out_error;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       overflow_clear = 1'b0;

  rx_fifo #(.INPUT_DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .received_data  (received_data),
    .data_is_valid  (data_is_valid),
    .rx_error       (rx_error),
    .out_data       (out_data),
    .out_error      (out_error),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit [8:0] q[$];
  bit [8:0] rd_log[$];
  bit       m_ovf = 1'b0;
  bit       m_dv = 1'b0;
  bit       chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a new rise of word-valid adds a word if there is room
  // (or a read leaves this cycle); otherwise it is lost and flagged.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_dv  = 1'b0;
      chk_en = 1'b1;
    end else begin
      bit take;
      bit rise;
      take = (q.size() > 0) && out_ready;
      rise = data_is_valid && !m_dv;
      if (take) rd_log.push_back(q.pop_front());
      if (rise) begin
        if (q.size() < DEPTH) q.push_back({rx_error, received_data});
        else m_ovf = 1'b1;
      end else if (overflow_clear) begin
        m_ovf = 1'b0;
      end
      if (rise && q.size() == DEPTH && !take && overflow_clear)
        m_ovf = 1'b1;
      m_dv = data_is_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) begin
        chk("head_data", 32'(out_data), 32'(q[0][7:0]));
        chk("head_err", 32'(out_error), 32'(q[0][8]));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    received_data = d;
    rx_error      = e;
    data_is_valid = 1'b1;
    tick();
    data_is_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick(DEPTH + 2);
    out_ready = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // 1: single pulse
    received_data = 8'hA5;
    data_is_valid = 1'b1;
    tick();
    data_is_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_err", 32'(out_error), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    drain();

    // 2: level held five cycles
    received_data = 8'h3C;
    data_is_valid = 1'b1;
    tick(5);
    data_is_valid = 1'b0;
    tick();
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_data", 32'(out_data), 32'h3C);
    drain();

    // 3: fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'd16);
    send(8'h10, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_count2", 32'(count), 32'd16);
    rd_log.delete();
    drain();
    chk("t3_nread", 32'(rd_log.size()), 32'd16);
    for (int i = 0; i < DEPTH; i++)
      if (i < rd_log.size())
        chk("t3_order", 32'(rd_log[i]), 32'(i));
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    chk("t3_clr", 32'(overflow), 32'd0);

    // 4: full with simultaneous capture and pop
    for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i), 1'b0);
    rd_log.delete();
    received_data = 8'h55;
    data_is_valid = 1'b1;
    out_ready     = 1'b1;
    tick();
    data_is_valid = 1'b0;
    out_ready     = 1'b0;
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd0);
    tick();
    drain();
    chk("t4_nread", 32'(rd_log.size()), 32'd17);
    if (rd_log.size() == 17) begin
      chk("t4_first", 32'(rd_log[0]), 32'h20);
      chk("t4_last", 32'(rd_log[16]), 32'h55);
    end

    // 5: error tag, then clear racing a drop
    send(8'h7E, 1'b1);
    chk("t5_err", 32'(out_error), 32'd1);
    chk("t5_data", 32'(out_data), 32'h7E);
    for (int i = 1; i < DEPTH; i++) send(8'(i), 1'b0);
    chk("t5_full", 32'(full), 32'd1);
    received_data  = 8'hEE;
    data_is_valid  = 1'b1;
    overflow_clear = 1'b1;
    tick();
    data_is_valid  = 1'b0;
    overflow_clear = 1'b0;
    chk("t5_ovf", 32'(overflow), 32'd1);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    drain();

    // 6: 40-word stream with random ready, wrapping the pointers
    rd_log.delete();
    for (int i = 0; i < 40; i++) begin
      received_data = 8'(8'h80 + i);
      rx_error      = 1'($urandom_range(0, 1));
      data_is_valid = 1'b1;
      out_ready     = ($urandom_range(0, 3) != 0);
      tick();
      data_is_valid = 1'b0;
      out_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk("t6_nread", 32'(rd_log.size()), 32'd40);
    for (int i = 0; i < 40; i++)
      if (i < rd_log.size())
        chk("t6_seq", 32'(rd_log[i][7:0]), 32'(8'h80 + i));
    chk("t6_ovf", 32'(overflow), 32'd0);

    // reset mid-stream
    for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), 1'b0);
    received_data = 8'hCF;
    data_is_valid = 1'b1;
    reset         = 1'b1;
    tick();
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_count", 32'(count), 32'd0);
    // level still high as reset releases: exactly one capture
    reset = 1'b0;
    tick(3);
    data_is_valid = 1'b0;
    tick();
    chk("t6_relcap", 32'(count), 32'd1);
    chk("t6_reldata", 32'(out_data), 32'hCF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
